xor_stream_decrypt: RTL and testbench
=====================================

Name: xor_stream_decrypt

Overview:
- Receive-side counterpart of the single-word XOR encrypt engine.
- Accepts a burst of ciphertext words over a valid/ready stream and XORs each word with a key captured at transaction start.
- Delivers plaintext through a one-entry output register with backpressure.
- Zeroizes the key and output data at the end of every transaction and on reset. Sits between the ciphertext link and the plaintext consumer.

Parameters:
- DATA_W, 32, width of key, ciphertext and plaintext words
- MAX_WORDS, 16, maximum words per transaction
- LEN_W, 5, width of len_in; must hold MAX_WORDS

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a transaction; sampled only in IDLE
- len_in  in  LEN_W  word count for the transaction, sampled with start
- key_in  in  DATA_W  key, sampled in LOAD_KEY
- ct_valid  in  1  ciphertext word valid
- ct_data  in  DATA_W  ciphertext word
- ct_ready  out  1  ciphertext word accepted when ct_valid&&ct_ready
- pt_valid  out  1  plaintext word valid
- pt_data  out  DATA_W  plaintext word
- pt_ready  in  1  consumer accepts when pt_valid&&pt_ready
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on CLEAR->IDLE
- err  out  1  one-cycle pulse on a rejected start

Behaviour:
- Reset (async, rst high): state=IDLE, key_reg=0, cnt=0, pt_data=0, pt_valid=0, ct_ready=0, busy=0, done=0, err=0. A reset mid-transaction drops all in-flight data; no done pulse.
- IDLE:
  - start with 1<=len_in<=MAX_WORDS: cnt<=len_in, go to LOAD_KEY.
  - start with len_in==0 or len_in>MAX_WORDS: err=1 next cycle, stay IDLE.
  - ct_ready=0.
- LOAD_KEY (1 cycle): key_reg<=key_in, go to STREAM, ct_ready=0.
- STREAM:
  - ct_ready = !pt_valid || pt_ready (combinational; output register may be refilled in the same cycle it drains).
  - On ct handshake: pt_data<=ct_data^key_reg, pt_valid<=1, cnt<=cnt-1.
  - If cnt==1 at the handshake, go to DRAIN.
  - pt handshake without a ct handshake: pt_valid<=0, pt_data holds its value.
- DRAIN:
  - ct_ready=0.
  - Stay while pt_valid && !pt_ready.
  - When the output is empty or being accepted this cycle: pt_valid<=0, go to CLEAR.
- CLEAR (1 cycle): key_reg<=0, pt_data<=0, done=1 next cycle, go to IDLE.
- Latency and throughput:
  - ct handshake in cycle N gives pt_valid in cycle N+1.
  - Sustained 1 word/cycle while pt_ready=1.
  - Overhead per transaction: LOAD_KEY + CLEAR = 2 cycles.
- Timing is constant: no data-dependent state, latency or early exit.
- start while busy is ignored: no err, no state change.
- pt_data is stable while pt_valid && !pt_ready.
- ct_valid outside STREAM is ignored and not consumed.
- Stream rules: ct_ready never depends on ct_valid. pt_valid, once high, does not drop until accepted.
- Arithmetic:
  - XOR is full DATA_W with no truncation.
  - cnt is LEN_W bits and decrements only on a ct handshake; it never wraps, because it leaves STREAM at 1.
- Round trip: a word encrypted with key K and decrypted here with key K returns the original word.

Decomposition:
- Shared package holds:
  - state enum: IDLE, LOAD_KEY, STREAM, DRAIN, CLEAR
  - DATA_W and MAX_WORDS defaults
  - localparam for state width
  - the same constants used by the encrypt engine
- One natural sub-module: pt_out_reg, a one-entry valid/ready register slice with a synchronous clear input. The FSM, counter and key register stay in the top.

Test Plan:
- Single word: start, len=1, key=0xA5A5_5A5A, ct=0xFFFF_0000 → pt=0x5A5A_5A5A one cycle after the handshake; done 2 cycles after pt accepted; key_reg=0 afterwards.
- Burst: len=4, pt_ready=1, ct words back-to-back → 4 consecutive pt_valid cycles, each equal to ct^key; busy high throughout; done once.
- Backpressure: len=3, pt_ready low for 5 cycles after the first word → ct_ready low, pt_data stable, no loss or duplication; order preserved after release.
- Bad length: start with len=0, then len=17 → err pulse each time; busy stays 0; ct_ready stays 0.
- Start while busy: second start mid-STREAM with a different key → ignored; outputs still use the first key; single done.
- Reset mid-STREAM after 2 of 4 words → all outputs and key_reg zero immediately; a subsequent len=1 transaction decrypts correctly with the new key.

Source files
------------

// File: rtl/xor_stream_decrypt_pkg.sv
// Shared definitions for the XOR stream encrypt/decrypt engines.
package xor_stream_decrypt_pkg;

    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned MAX_WORDS_DEF = 16;
    localparam int unsigned LEN_W_DEF     = 5;
    localparam int unsigned STATE_W       = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 3'd0,
        LOAD_KEY = 3'd1,
        STREAM   = 3'd2,
        DRAIN    = 3'd3,
        CLEAR    = 3'd4
    } state_t;

endpackage

// File: rtl/xor_stream_decrypt_pt_out.sv
// One-entry valid/ready output register with synchronous clear.
module pt_out_reg #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    // Load wins over drain so the slot can be refilled in the cycle it empties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/xor_stream_decrypt.sv
// Receive-side XOR stream decryptor: burst of ciphertext words XORed with a
// per-transaction key, delivered through a one-entry output register.
module xor_stream_decrypt
    import xor_stream_decrypt_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_WORDS = MAX_WORDS_DEF,
    parameter int unsigned LEN_W     = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len_in,
    input  logic [DATA_W-1:0] key_in,
    input  logic              ct_valid,
    input  logic [DATA_W-1:0] ct_data,
    output logic              ct_ready,
    output logic              pt_valid,
    output logic [DATA_W-1:0] pt_data,
    input  logic              pt_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state;
    logic [DATA_W-1:0] key_reg;
    logic [LEN_W-1:0]  cnt;
    logic              ct_hs;
    logic              len_ok;

    assign ct_ready = (state == STREAM) && (!pt_valid || pt_ready);
    assign ct_hs    = ct_valid && ct_ready;
    assign busy     = (state != IDLE);
    assign len_ok   = (len_in != '0) && (len_in <= LEN_W'(MAX_WORDS));

    pt_out_reg #(
        .DATA_W (DATA_W)
    ) u_pt_out (
        .clk       (clk),
        .rst       (rst),
        .clear     (state == CLEAR),
        .load      (ct_hs),
        .load_data (ct_data ^ key_reg),
        .out_ready (pt_ready),
        .out_valid (pt_valid),
        .out_data  (pt_data)
    );

    // Transaction FSM, word counter, key register and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            key_reg <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            cnt   <= len_in;
                            state <= LOAD_KEY;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD_KEY: begin
                    key_reg <= key_in;
                    state   <= STREAM;
                end
                STREAM: begin
                    if (ct_hs) begin
                        cnt <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!(pt_valid && !pt_ready)) begin
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    key_reg <= '0;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_stream_decrypt.sv
// Scoreboard bench for xor_stream_decrypt: stimulus pushes expected plaintext,
// a monitor pops and compares on every pt handshake.
module tb_xor_stream_decrypt;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  len_in = '0;
    logic [31:0] key_in = '0;
    logic        ct_valid = 1'b0;
    logic [31:0] ct_data = '0;
    logic        ct_ready;
    logic        pt_valid;
    logic [31:0] pt_data;
    logic        pt_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int done_cyc = 0;
    int last_pop_cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ct_v[4];
    logic [31:0] pt_v[4];

    xor_stream_decrypt #(
        .DATA_W    (32),
        .MAX_WORDS (16),
        .LEN_W     (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len_in   (len_in),
        .key_in   (key_in),
        .ct_valid (ct_valid),
        .ct_data  (ct_data),
        .ct_ready (ct_ready),
        .pt_valid (pt_valid),
        .pt_data  (pt_data),
        .pt_ready (pt_ready),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each accepted plaintext word against the scoreboard.
    always @(negedge clk) begin
        if (!rst && pt_valid && pt_ready) begin
            if (exp_q.size() == 0) begin
                chk("pt_unexpected", pt_data, 32'hxxxx_xxxx);
            end else begin
                chk("pt_data", pt_data, exp_q.pop_front());
                last_pop_cyc = cyc;
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err) err_cnt++;
    end

    // Issue start, then offer n ciphertext words from ct_v; push pt_v on each handshake.
    task automatic run_txn(input logic [4:0] len, input logic [31:0] key, input int n,
                           input bit mid_start, output int stalls);
        int waited;
        bit ok;
        stalls = 0;
        @(posedge clk); #1;
        start = 1'b1; len_in = len; key_in = key;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            ct_valid = 1'b1;
            ct_data  = ct_v[i];
            ok = 1'b0;
            waited = 0;
            while (!ok) begin
                @(negedge clk);
                if (ct_ready) begin
                    ok = 1'b1;
                end else begin
                    waited++;
                    if (i > 0) stalls++;
                    if (waited > 50) begin
                        chk("ct_handshake_timeout", 32'd0, 32'd1);
                        ct_valid = 1'b0;
                        return;
                    end
                end
            end
            chk("busy_in_stream", {31'd0, busy}, 32'd1);
            exp_q.push_back(pt_v[i]);
            @(posedge clk); #1;
            chk("pt_valid_after_hs", {31'd0, pt_valid}, 32'd1);
            if (mid_start && i == 0) begin
                start = 1'b1; len_in = 5'd1; key_in = 32'hFFFF_FFFF;
            end else begin
                start = 1'b0;
            end
        end
        ct_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int k = 0;
        while (done_cnt == base && k < 40) begin
            @(negedge clk); #1;
            k++;
        end
        chk("done_seen", {31'd0, done_cnt > base}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("done_once", done_cnt - base, 32'd1);
        chk("key_zeroized", dut.key_reg, 32'd0);
        chk("pt_data_zeroized", pt_data, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        int base;
        int ebase;

        // Reset state
        #12;
        chk("rst_ct_ready", {31'd0, ct_ready}, 32'd0);
        chk("rst_pt_valid", {31'd0, pt_valid}, 32'd0);
        chk("rst_pt_data", pt_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        chk("rst_key", dut.key_reg, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single word: 0xFFFF0000 ^ 0xA5A55A5A = 0x5A5A5A5A
        ct_v[0] = 32'hFFFF_0000; pt_v[0] = 32'h5A5A_5A5A;
        base = done_cnt;
        run_txn(5'd1, 32'hA5A5_5A5A, 1, 1'b0, stalls);
        wait_done(base);
        chk("done_latency", done_cyc - last_pop_cyc, 32'd2);

        // Burst of 4 with key 0x0F0F0F0F, no backpressure
        ct_v[0] = 32'h1234_5678; pt_v[0] = 32'h1D3B_5977;
        ct_v[1] = 32'h0000_0000; pt_v[1] = 32'h0F0F_0F0F;
        ct_v[2] = 32'hFFFF_FFFF; pt_v[2] = 32'hF0F0_F0F0;
        ct_v[3] = 32'hDEAD_BEEF; pt_v[3] = 32'hD1A2_B1E0;
        base = done_cnt;
        run_txn(5'd4, 32'h0F0F_0F0F, 4, 1'b0, stalls);
        chk("burst_stalls", stalls, 32'd0);
        wait_done(base);

        // Backpressure: consumer stalls 5 cycles after the first word
        ct_v[0] = 32'h2222_2222; pt_v[0] = 32'h3333_3333;
        ct_v[1] = 32'h4444_4444; pt_v[1] = 32'h5555_5555;
        ct_v[2] = 32'h8888_8888; pt_v[2] = 32'h9999_9999;
        base = done_cnt;
        pt_ready = 1'b0;
        fork
            run_txn(5'd3, 32'h1111_1111, 3, 1'b0, stalls);
            begin
                int k = 0;
                while (!pt_valid && k < 40) begin
                    @(negedge clk);
                    k++;
                end
                chk("bp_pt_valid_seen", {31'd0, pt_valid}, 32'd1);
                for (int j = 0; j < 5; j++) begin
                    if (j > 0) @(negedge clk);
                    chk("bp_ct_ready_low", {31'd0, ct_ready}, 32'd0);
                    chk("bp_pt_stable", pt_data, 32'h3333_3333);
                end
                @(posedge clk); #1;
                pt_ready = 1'b1;
            end
        join
        wait_done(base);

        // Bad lengths: 0 and 17 each give one err pulse and no activity
        ebase = err_cnt;
        @(posedge clk); #1; start = 1'b1; len_in = 5'd0;
        @(posedge clk); #1; start = 1'b0;
        chk("err_len0", {31'd0, err}, 32'd1);
        chk("err_len0_busy", {31'd0, busy}, 32'd0);
        chk("err_len0_ct_ready", {31'd0, ct_ready}, 32'd0);
        @(posedge clk); #1;
        chk("err_pulse_width", {31'd0, err}, 32'd0);
        start = 1'b1; len_in = 5'd17;
        @(posedge clk); #1; start = 1'b0;
        chk("err_len17", {31'd0, err}, 32'd1);
        chk("err_len17_busy", {31'd0, busy}, 32'd0);
        chk("err_len17_ct_ready", {31'd0, ct_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("err_count", err_cnt - ebase, 32'd2);

        // Start while busy is ignored; first key 0xCAFEBABE stays in use
        ct_v[0] = 32'h0000_0000; pt_v[0] = 32'hCAFE_BABE;
        ct_v[1] = 32'h0000_0001; pt_v[1] = 32'hCAFE_BABF;
        base = done_cnt;
        ebase = err_cnt;
        run_txn(5'd2, 32'hCAFE_BABE, 2, 1'b1, stalls);
        wait_done(base);
        chk("busy_start_no_err", err_cnt - ebase, 32'd0);

        // Reset after 2 of 4 words drops everything
        ct_v[0] = 32'h0101_0101; pt_v[0] = 32'h0000_0000;
        ct_v[1] = 32'h0202_0202; pt_v[1] = 32'h0303_0303;
        base = done_cnt;
        run_txn(5'd4, 32'h0101_0101, 2, 1'b0, stalls);
        rst = 1'b1;
        #2;
        chk("midrst_pt_valid", {31'd0, pt_valid}, 32'd0);
        chk("midrst_pt_data", pt_data, 32'd0);
        chk("midrst_ct_ready", {31'd0, ct_ready}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_key", dut.key_reg, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_no_done", done_cnt - base, 32'd0);

        // Fresh single word after reset: 0xFFFFFFFF ^ 0x13579BDF = 0xECA86420
        ct_v[0] = 32'hFFFF_FFFF; pt_v[0] = 32'hECA8_6420;
        base = done_cnt;
        run_txn(5'd1, 32'h1357_9BDF, 1, 1'b0, stalls);
        wait_done(base);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
